// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared types, limits and frame-length helper for the UART
// receive frame register (rx_frame_sr).
// Optional feature macro: RX_FRAME_PARITY_EN adds one parity bit per frame.
package rx_frame_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_frame_state_t;

  localparam int MIN_DATA_BITS = 5;
  localparam int MAX_DATA_BITS = 9;
  localparam int MAX_STOP_BITS = 2;

`ifdef RX_FRAME_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  // Total serial bits per frame: data, optional parity, stop bits.
  function automatic int frame_bits(input int data_bits, input int stop_bits, input int parity);
    return data_bits + parity + stop_bits;
  endfunction

endpackage

// File: rtl/rx_frame_shifter.sv
// rx_frame_shifter: serial-in / parallel-out chain. New bits enter at the MSB
// and move towards bit 0, so after WIDTH shifts the earliest bit sits at [0].
// Ports:
//   clk, n_rst   clock, asynchronous active-low reset (chain -> all 1s)
//   load_ones_i  synchronous load of all 1s (idle line); wins over shift
//   shift_en_i   shift serial_i into the chain this cycle
//   serial_i     incoming line bit
//   chain_o      current chain contents
module rx_frame_shifter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_ones_i,
  input  logic             shift_en_i,
  input  logic             serial_i,
  output logic [WIDTH-1:0] chain_o
);

  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] chain_d;

  // Next chain value: idle fill has priority over a shift.
  always_comb begin
    chain_d = chain_q;
    if (load_ones_i) begin
      chain_d = '1;
    end else if (shift_en_i) begin
      chain_d = {serial_i, chain_q[WIDTH-1:1]};
    end else begin
      chain_d = chain_q;
    end
  end

  // Chain register, reset to the idle-line pattern.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign chain_o = chain_q;

endmodule

// File: rtl/rx_frame_sr.sv
// rx_frame_sr: UART receive frame register. Counts strobed serial bits,
// and at the frame boundary captures data, parity and stop bits into holding
// registers, pulsing frame_done for one cycle.
// Optional feature macro: RX_FRAME_PARITY_EN (one parity bit after the data).
// Ports:
//   clk, n_rst     clock, asynchronous active-low reset
//   clear          synchronous abort of the partial frame (wins over strobe)
//   shift_strobe   sample serial_in this cycle
//   serial_in      synchronised receive line
//   packet_data    data of the last completed frame
//   stop_bit       AND of the last frame's stop bits
//   frame_done     one-cycle pulse after the final strobe of a frame
//   framing_error  NOT stop_bit of the last frame
//   parity_error   parity check failure of the last frame (0 without parity)
//   busy           a frame is partially received
module rx_frame_sr
  import rx_frame_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 shift_strobe,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] packet_data,
  output logic                 stop_bit,
  output logic                 frame_done,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int FRAME_BITS = frame_bits(DATA_BITS, STOP_BITS, PARITY_BITS);
  // The counter only ever holds 0..FRAME_BITS-1.
  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BITS - 1);

  rx_frame_state_t       state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  load_s;
  logic [FRAME_BITS-2:0] chain_s;
  logic [FRAME_BITS-1:0] frame_s;
  logic [DATA_BITS-1:0]  data_s;
  logic                  stop_s;

  logic [DATA_BITS-1:0]  packet_data_q;
  logic                  stop_bit_q;
  logic                  frame_done_q;
  logic                  framing_error_q;

  // The chain holds the first FRAME_BITS-1 bits; the final bit is taken
  // straight from serial_in so the capture happens on the final strobe edge.
  rx_frame_shifter #(
    .WIDTH (FRAME_BITS - 1)
  ) u_shifter (
    .clk         (clk),
    .n_rst       (n_rst),
    .load_ones_i (clear),
    .shift_en_i  (shift_strobe),
    .serial_i    (serial_in),
    .chain_o     (chain_s)
  );

  assign frame_s = {serial_in, chain_s};

  // Bit counter / FSM next state; clear discards any same-cycle strobe.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    load_s  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (shift_strobe) begin
      case (state_q)
        IDLE: begin
          state_d = SHIFT;
          count_d = CW'(1);
        end
        SHIFT: begin
          if (count_q == LAST_CNT) begin
            state_d = IDLE;
            count_d = '0;
            load_s  = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
      count_d = count_q;
    end
  end

  // FSM state and bit counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Data bit k (arrival order) maps to [k] or [DATA_BITS-1-k].
  always_comb begin
    data_s = '0;
    for (int k = 0; k < DATA_BITS; k++) begin
      if (LSB_FIRST != 0) begin
        data_s[k] = frame_s[k];
      end else begin
        data_s[DATA_BITS-1-k] = frame_s[k];
      end
    end
  end

  assign stop_s = &frame_s[FRAME_BITS-1 -: STOP_BITS];

  // Holding registers and done pulse, loaded on the final strobe.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      packet_data_q   <= '0;
      stop_bit_q      <= 1'b1;
      frame_done_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      frame_done_q <= load_s;
      if (load_s) begin
        packet_data_q   <= data_s;
        stop_bit_q      <= stop_s;
        framing_error_q <= ~stop_s;
      end else begin
        packet_data_q   <= packet_data_q;
        stop_bit_q      <= stop_bit_q;
        framing_error_q <= framing_error_q;
      end
    end
  end

`ifdef RX_FRAME_PARITY_EN
  logic parity_err_s;
  logic parity_error_q;

  // Parity bit sits at frame_s[DATA_BITS], right after the data bits.
  assign parity_err_s = (^frame_s[DATA_BITS:0]) != 1'(PARITY_ODD);

  // Parity flag register, loaded alongside the other holding registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_error_q <= 1'b0;
    end else if (load_s) begin
      parity_error_q <= parity_err_s;
    end else begin
      parity_error_q <= parity_error_q;
    end
  end

  assign parity_error = parity_error_q;
`else
  // No parity bit in the frame: the flag is constant 0 and PARITY_ODD has
  // no effect (it is only referenced to keep the parameter in use).
  assign parity_error = 1'b0 & 1'(PARITY_ODD);
`endif

  assign packet_data   = packet_data_q;
  assign stop_bit      = stop_bit_q;
  assign frame_done    = frame_done_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q == SHIFT);

endmodule

// File: tb/tb_rx_frame_sr.sv
// Bench for rx_frame_sr: two instances (8/1/LSB-first/even and
// 5/2/MSB-first/odd) checked every cycle against a queue-based frame model,
// with directed scenarios pinned by literal expectations, then random traffic.
module tb_rx_frame_sr;

`ifdef RX_FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  localparam int DB [2] = '{8, 5};
  localparam int SB [2] = '{1, 2};
  localparam int LF [2] = '{1, 0};
  localparam int PO [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       clr0, stb0, sin0, clr1, stb1, sin1;
  logic [7:0] pd0;
  logic [4:0] pd1;
  logic       sb0, fd0, fe0, pe0, bz0;
  logic       sb1, fd1, fe1, pe1, bz1;

  rx_frame_sr #(.DATA_BITS(8), .STOP_BITS(1), .LSB_FIRST(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .clear(clr0), .shift_strobe(stb0), .serial_in(sin0),
    .packet_data(pd0), .stop_bit(sb0), .frame_done(fd0), .framing_error(fe0),
    .parity_error(pe0), .busy(bz0));

  rx_frame_sr #(.DATA_BITS(5), .STOP_BITS(2), .LSB_FIRST(0), .PARITY_ODD(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .clear(clr1), .shift_strobe(stb1), .serial_in(sin1),
    .packet_data(pd1), .stop_bit(sb1), .frame_done(fd1), .framing_error(fe1),
    .parity_error(pe1), .busy(bz1));

  // Behavioural model: list of bits received in the current frame.
  int         qlen [2];
  bit         qb [2][16];
  logic [8:0] e_data [2];
  bit         e_stop [2], e_done [2], e_fe [2], e_pe [2], e_busy [2];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs after the coming clock edge, from the frame rules.
  task automatic model_step(input int i, input bit rst_low, input bit clr, input bit stb, input bit b);
    int fb;
    bit x;
    fb = DB[i] + PB + SB[i];
    if (rst_low) begin
      qlen[i] = 0; e_data[i] = 9'h000; e_stop[i] = 1'b1; e_fe[i] = 1'b0;
      e_pe[i] = 1'b0; e_done[i] = 1'b0; e_busy[i] = 1'b0;
      return;
    end
    e_done[i] = 1'b0;
    if (clr) begin
      qlen[i] = 0;
    end else if (stb) begin
      qb[i][qlen[i]] = b;
      qlen[i]++;
      if (qlen[i] == fb) begin
        e_data[i] = 9'h000;
        for (int k = 0; k < DB[i]; k++)
          e_data[i][(LF[i] != 0) ? k : DB[i] - 1 - k] = qb[i][k];
        e_stop[i] = 1'b1;
        for (int s = 0; s < SB[i]; s++) e_stop[i] = e_stop[i] & qb[i][DB[i] + PB + s];
        e_fe[i] = !e_stop[i];
        x = 1'b0;
        for (int k = 0; k < DB[i] + PB; k++) x = x ^ qb[i][k];
        e_pe[i] = (PB == 1) ? (x != (PO[i] != 0)) : 1'b0;
        e_done[i] = 1'b1;
        qlen[i] = 0;
      end
    end
    e_busy[i] = (qlen[i] > 0);
  endtask

  task automatic compare_all();
    chk("pd0", 32'(pd0), 32'(e_data[0][7:0]));
    chk("sb0", 32'(sb0), 32'(e_stop[0]));
    chk("fd0", 32'(fd0), 32'(e_done[0]));
    chk("fe0", 32'(fe0), 32'(e_fe[0]));
    chk("pe0", 32'(pe0), 32'(e_pe[0]));
    chk("bz0", 32'(bz0), 32'(e_busy[0]));
    chk("pd1", 32'(pd1), 32'(e_data[1][4:0]));
    chk("sb1", 32'(sb1), 32'(e_stop[1]));
    chk("fd1", 32'(fd1), 32'(e_done[1]));
    chk("fe1", 32'(fe1), 32'(e_fe[1]));
    chk("pe1", 32'(pe1), 32'(e_pe[1]));
    chk("bz1", 32'(bz1), 32'(e_busy[1]));
  endtask

  // One clock: drive inputs, advance the model, sample after the edge.
  task automatic cycle(input bit rst_low, input bit c0, input bit s0, input bit b0,
                       input bit c1, input bit s1, input bit b1);
    n_rst = !rst_low;
    clr0 = c0; stb0 = s0; sin0 = b0;
    clr1 = c1; stb1 = s1; sin1 = b1;
    model_step(0, rst_low, c0, s0, b0);
    model_step(1, rst_low, c1, s1, b1);
    @(posedge clk);
    #2;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame on dut0: 8 data bits LSB first, even parity (optionally wrong), stop.
  task automatic send0(input logic [7:0] d, input bit par_bad, input bit stp);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, d[k], 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < PB; p++) cycle(1'b0, 1'b0, 1'b1, (^d) ^ par_bad, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, stp, 1'b0, 1'b0, 1'b0);
  endtask

  // Frame on dut1: arr[k] is the k-th arriving data bit, then parity, stops.
  task automatic send1(input logic [4:0] arr, input bit par, input logic [1:0] stops);
    for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, arr[k]);
    for (int p = 0; p < PB; p++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, par);
    for (int s = 0; s < 2; s++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, stops[s]);
  endtask

  initial begin
    bit r, c0, s0, b0, c1, s1, b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("rst_pd0", 32'(pd0), 32'h0);
    chk("rst_sb0", 32'(sb0), 32'h1);
    chk("rst_fd0", 32'(fd0), 32'h0);
    chk("rst_bz0", 32'(bz0), 32'h0);
    idle();

    // A5 with good stop
    send0(8'hA5, 1'b0, 1'b1);
    chk("a5_done", 32'(fd0), 32'h1);
    chk("a5_data", 32'(pd0), 32'hA5);
    chk("a5_stop", 32'(sb0), 32'h1);
    chk("a5_fe", 32'(fe0), 32'h0);
    chk("a5_model", 32'(e_data[0]), 32'h0A5);
    idle();
    chk("a5_pulse_end", 32'(fd0), 32'h0);

    // A5 with bad stop, flag holds until the next good frame
    send0(8'hA5, 1'b0, 1'b0);
    chk("fe_set", 32'(fe0), 32'h1);
    repeat (5) idle();
    chk("fe_hold", 32'(fe0), 32'h1);
    chk("fe_hold_data", 32'(pd0), 32'hA5);

    // Partial frame, clear+strobe together, then 3C
    repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("partial_busy", 32'(bz0), 32'h1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("clear_busy", 32'(bz0), 32'h0);
    send0(8'h3C, 1'b0, 1'b1);
    chk("3c_done", 32'(fd0), 32'h1);
    chk("3c_data", 32'(pd0), 32'h3C);
    chk("3c_fe", 32'(fe0), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("3c_hold_after_clear", 32'(pd0), 32'h3C);

    // Back-to-back frames
    send0(8'h01, 1'b0, 1'b1);
    chk("b2b1_done", 32'(fd0), 32'h1);
    chk("b2b1_data", 32'(pd0), 32'h01);
    send0(8'hFF, 1'b0, 1'b1);
    chk("b2b2_done", 32'(fd0), 32'h1);
    chk("b2b2_data", 32'(pd0), 32'hFF);
    idle();

`ifdef RX_FRAME_PARITY_EN
    send0(8'h07, 1'b0, 1'b1);
    chk("par_even_ok", 32'(pe0), 32'h0);
    send0(8'h07, 1'b1, 1'b1);
    chk("par_even_bad", 32'(pe0), 32'h1);
    send1(5'b00111, 1'b1, 2'b11);
    chk("par_odd_data", 32'(pd1), 32'h1C);
    chk("par_odd_flag", 32'(pe1), 32'h1);
    idle();
`endif

    // dut1: 5 bits MSB-first, second stop bit 0
    send1(5'b00001, 1'b0, 2'b01);
    chk("d5_done", 32'(fd1), 32'h1);
    chk("d5_data", 32'(pd1), 32'h10);
    chk("d5_fe", 32'(fe1), 32'h1);
    chk("d5_model", 32'(e_data[1]), 32'h010);

    // Reset mid-frame
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("mr_pd1", 32'(pd1), 32'h0);
    chk("mr_sb1", 32'(sb1), 32'h1);
    chk("mr_fe1", 32'(fe1), 32'h0);
    chk("mr_bz1", 32'(bz1), 32'h0);
    chk("mr_pd0", 32'(pd0), 32'h0);
    repeat (12) idle();
    chk("mr_no_done", 32'(fd1), 32'h0);

    // Random traffic
    for (int n = 0; n < 5000; n++) begin
      r  = ($urandom_range(0, 999) == 0);
      c0 = ($urandom_range(0, 39) == 0);
      c1 = ($urandom_range(0, 39) == 0);
      s0 = ($urandom_range(0, 2) != 0);
      s1 = ($urandom_range(0, 1) != 0);
      b0 = ($urandom_range(0, 3) != 0);
      b1 = ($urandom_range(0, 3) != 0);
      cycle(r, c0, s0, b0, c1, s1, b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
